// File: rtl/elevator_pkg.sv
// Elevator controller shared definitions: FSM state encoding and width helpers.
// Optional feature macro used by this slice: ELEV_DOOR_REOPEN_EN.
package elevator_pkg;

    // State codes, also driven straight onto the status LED output
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_MOVE_UP    = 3'd1;
    localparam logic [2:0] ST_MOVE_DOWN  = 3'd2;
    localparam logic [2:0] ST_DOOR_OPEN  = 3'd3;
    localparam logic [2:0] ST_DOOR_CLOSE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_MOVE_UP    = ST_MOVE_UP,
        S_MOVE_DOWN  = ST_MOVE_DOWN,
        S_DOOR_OPEN  = ST_DOOR_OPEN,
        S_DOOR_CLOSE = ST_DOOR_CLOSE
    } state_t;

    // Bits needed for a floor index; never less than one bit
    function automatic int floorWidth(input int floors);
        return (floors <= 2) ? 1 : $clog2(floors);
    endfunction

    // Bits needed for a timer that must reach the larger of two tick counts
    function automatic int cntWidth(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/elevator_if.sv
// Elevator controller signal bundle: car sensors, call buttons, motor/door drives and status.
// The master side is the building (sensors, buttons); the slave side is the controller.
interface elevator_if
    import elevator_pkg::*;
#(
    parameter int FLOORS = 4
) ();

    localparam int FW = floorWidth(FLOORS);

    logic [FLOORS-1:0] floor_sns;
    logic [FLOORS-1:0] req_btn;
    logic              door_btn;
    logic              motor_up;
    logic              motor_down;
    logic              door_open;
    logic [FLOORS-1:0] req_led;
    logic [FW-1:0]     cur_floor;
    logic              dir_up;
    logic [2:0]        state;

    modport master (
        output floor_sns, req_btn, door_btn,
        input  motor_up, motor_down, door_open, req_led, cur_floor, dir_up, state
    );

    modport slave (
        input  floor_sns, req_btn, door_btn,
        output motor_up, motor_down, door_open, req_led, cur_floor, dir_up, state
    );

endinterface

// File: rtl/elevator_ctrl_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous level inputs.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor calls, drives the motor towards them,
// and runs a timed door open/close cycle at each served floor.
// Optional macro ELEV_DOOR_REOPEN_EN: a call or door button at the current
// floor during door closing reopens the door for a full open period.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS      = 4,
    parameter int DOOR_TICKS  = 50_000_000,
    parameter int CLOSE_TICKS = 25_000_000
) (
    input logic       clk,
    input logic       rstn,
    elevator_if.slave bus
);

    localparam int FW = floorWidth(FLOORS);
    localparam int CW = cntWidth(DOOR_TICKS, CLOSE_TICKS);
    localparam logic [CW-1:0] DOOR_LAST  = CW'(DOOR_TICKS - 1);
    localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [FW-1:0] TOP_FLOOR  = FW'(FLOORS - 1);
    localparam logic [FLOORS-1:0] ONE_MASK = {{(FLOORS-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_motorUp;
    logic              r_motorDown;
    logic              r_doorOpen;
    logic              r_dirUp;
    logic [FLOORS-1:0] r_req;
    logic [FW-1:0]     r_curFloor;
    logic              r_floorKnown;
    logic [CW-1:0]     r_cnt;

    logic [FLOORS-1:0] w_sns;
    logic [4:0]        w_ones;
    logic              w_atFloor;
    logic [FW-1:0]     w_atIdx;
    logic [FLOORS-1:0] w_atMask;
    logic [FLOORS-1:0] w_curMask;
    logic              w_reqHere;
    logic              w_reqAtIdx;
    logic              w_reqAbove;
    logic              w_reqBelow;
    logic              w_hereCall;
    logic [FLOORS-1:0] w_clrMask;

    sync2 #(.WIDTH(FLOORS)) u_snsSync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (bus.floor_sns),
        .o_sync  (w_sns)
    );

    // Decode the synchronised sensors: only a single active bit names a floor
    always_comb begin
        w_ones  = '0;
        w_atIdx = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (w_sns[i]) begin
                w_ones  = w_ones + 5'd1;
                w_atIdx = FW'(i);
            end
        end
        w_atFloor = (w_ones == 5'd1);
    end

    // Pending calls relative to the car's last known floor
    always_comb begin
        w_reqAbove = 1'b0;
        w_reqBelow = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (r_req[i] && (i > int'(r_curFloor))) w_reqAbove = 1'b1;
            if (r_req[i] && (i < int'(r_curFloor))) w_reqBelow = 1'b1;
        end
    end

    assign w_curMask  = ONE_MASK << r_curFloor;
    assign w_atMask   = ONE_MASK << w_atIdx;
    assign w_reqHere  = |(r_req & w_curMask);
    assign w_reqAtIdx = |(r_req & w_atMask);
    assign w_hereCall = bus.door_btn | (|(bus.req_btn & w_curMask));

    // Call bits to drop this cycle: the floor being served never stays latched
    always_comb begin
        w_clrMask = '0;
        case (r_state)
            S_IDLE:       if (r_floorKnown && w_reqHere) w_clrMask = w_curMask;
            S_MOVE_UP,
            S_MOVE_DOWN:  if (w_atFloor && w_reqAtIdx) w_clrMask = w_atMask;
            S_DOOR_OPEN:  w_clrMask = w_curMask;
`ifdef ELEV_DOOR_REOPEN_EN
            S_DOOR_CLOSE: if (w_hereCall) w_clrMask = w_curMask;
`endif
            default:      w_clrMask = '0;
        endcase
    end

    // Main controller: call latch, floor tracking, motion and door sequencing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_motorUp    <= 1'b0;
            r_motorDown  <= 1'b0;
            r_doorOpen   <= 1'b0;
            r_dirUp      <= 1'b1;
            r_req        <= '0;
            r_curFloor   <= '0;
            r_floorKnown <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_req <= (r_req | bus.req_btn) & ~w_clrMask;
            if (w_atFloor) begin
                r_curFloor   <= w_atIdx;
                r_floorKnown <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_motorUp   <= 1'b0;
                    r_motorDown <= 1'b0;
                    r_doorOpen  <= 1'b0;
                    if (r_floorKnown) begin
                        if (w_reqHere) begin
                            r_state    <= S_DOOR_OPEN;
                            r_doorOpen <= 1'b1;
                            r_cnt      <= '0;
                        end else if (r_dirUp && w_reqAbove) begin
                            r_state   <= S_MOVE_UP;
                            r_motorUp <= 1'b1;
                            r_dirUp   <= 1'b1;
                        end else if (w_reqBelow) begin
                            r_state     <= S_MOVE_DOWN;
                            r_motorDown <= 1'b1;
                            r_dirUp     <= 1'b0;
                        end else if (w_reqAbove) begin
                            r_state   <= S_MOVE_UP;
                            r_motorUp <= 1'b1;
                            r_dirUp   <= 1'b1;
                        end
                    end
                end
                S_MOVE_UP, S_MOVE_DOWN: begin
                    if (w_atFloor && w_reqAtIdx) begin
                        r_state     <= S_DOOR_OPEN;
                        r_motorUp   <= 1'b0;
                        r_motorDown <= 1'b0;
                        r_doorOpen  <= 1'b1;
                        r_cnt       <= '0;
                    end else if (w_atFloor &&
                                 (((r_state == S_MOVE_UP) && (w_atIdx == TOP_FLOOR)) ||
                                  ((r_state == S_MOVE_DOWN) && (w_atIdx == '0)))) begin
                        r_state     <= S_IDLE;
                        r_motorUp   <= 1'b0;
                        r_motorDown <= 1'b0;
                    end
                end
                S_DOOR_OPEN: begin
                    if (w_hereCall) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= DOOR_LAST) begin
                        r_state    <= S_DOOR_CLOSE;
                        r_doorOpen <= 1'b0;
                        r_cnt      <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DOOR_CLOSE: begin
`ifdef ELEV_DOOR_REOPEN_EN
                    if (w_hereCall) begin
                        r_state    <= S_DOOR_OPEN;
                        r_doorOpen <= 1'b1;
                        r_cnt      <= '0;
                    end else
`endif
                    if (r_cnt >= CLOSE_LAST) begin
                        r_cnt <= '0;
                        if (r_dirUp && w_reqAbove) begin
                            r_state   <= S_MOVE_UP;
                            r_motorUp <= 1'b1;
                        end else if (!r_dirUp && w_reqBelow) begin
                            r_state     <= S_MOVE_DOWN;
                            r_motorDown <= 1'b1;
                        end else if (r_dirUp && w_reqBelow) begin
                            r_state     <= S_MOVE_DOWN;
                            r_motorDown <= 1'b1;
                            r_dirUp     <= 1'b0;
                        end else if (!r_dirUp && w_reqAbove) begin
                            r_state   <= S_MOVE_UP;
                            r_motorUp <= 1'b1;
                            r_dirUp   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_motorUp   <= 1'b0;
                    r_motorDown <= 1'b0;
                    r_doorOpen  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motor_up   = r_motorUp;
    assign bus.motor_down = r_motorDown;
    assign bus.door_open  = r_doorOpen;
    assign bus.req_led    = r_req;
    assign bus.cur_floor  = r_curFloor;
    assign bus.dir_up     = r_dirUp;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (4 floors, 8 open ticks, 4 close ticks) with a
// simple car model that moves one half-floor every six motor cycles.
// Honours ELEV_DOOR_REOPEN_EN for the door-closing expectations.
module tb_elevator_ctrl;

    localparam int FLOORS      = 4;
    localparam int DOOR_TICKS  = 8;
    localparam int CLOSE_TICKS = 4;
    localparam int WAIT_LIMIT  = 400;
    localparam int STEP_CYCLES = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_UP    = 3'd1;
    localparam logic [2:0] ST_DOWN  = 3'd2;
    localparam logic [2:0] ST_OPEN  = 3'd3;
    localparam logic [2:0] ST_CLOSE = 3'd4;

    logic       clk;
    logic       rstn;
    int         checks = 0;
    int         failures = 0;
    int         carPos;
    int         carTick;
    logic       snsOverride;
    logic [3:0] snsForced;
    logic       bothSeen;
    int         doorOpens;

    elevator_if #(.FLOORS(FLOORS)) bus ();

    elevator_ctrl #(
        .FLOORS      (FLOORS),
        .DOOR_TICKS  (DOOR_TICKS),
        .CLOSE_TICKS (CLOSE_TICKS)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Car model: motor drive moves the car, sensors show whole-floor positions only
    initial begin
        carPos        = 2;
        carTick       = 0;
        snsOverride   = 1'b0;
        snsForced     = 4'b0000;
        bus.floor_sns = 4'b0010;
        forever begin
            @(negedge clk);
            if (bus.motor_up === 1'b1 && bus.motor_down !== 1'b1) begin
                carTick++;
                if (carTick >= STEP_CYCLES) begin
                    carTick = 0;
                    if (carPos < 2 * (FLOORS - 1)) carPos++;
                end
            end else if (bus.motor_down === 1'b1 && bus.motor_up !== 1'b1) begin
                carTick++;
                if (carTick >= STEP_CYCLES) begin
                    carTick = 0;
                    if (carPos > 0) carPos--;
                end
            end else begin
                carTick = 0;
            end
            bus.floor_sns = snsOverride ? snsForced :
                            ((carPos % 2 == 0) ? (4'b0001 << (carPos / 2)) : 4'b0000);
        end
    end

    // Watch for both motor drives at once and count door openings
    initial begin
        logic prevDoor;
        bothSeen  = 1'b0;
        doorOpens = 0;
        prevDoor  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.motor_up === 1'b1 && bus.motor_down === 1'b1) bothSeen = 1'b1;
            if (bus.door_open === 1'b1 && prevDoor !== 1'b1) doorOpens++;
            prevDoor = bus.door_open;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] calls);
        bus.req_btn = calls;
        @(negedge clk);
        bus.req_btn = 4'b0000;
    endtask

    task automatic waitState(input logic [2:0] target, input string tag);
        int n;
        n = 0;
        while (bus.state !== target && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, bus.state === target}, 32'd1);
    endtask

    task automatic waitLeave(input logic [2:0] from, output logic [2:0] observed);
        int n;
        n = 0;
        while (bus.state === from && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        observed = bus.state;
    endtask

    task automatic waitFloor(input logic [1:0] target, input string tag);
        int n;
        n = 0;
        while (bus.cur_floor !== target && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, bus.cur_floor === target}, 32'd1);
    endtask

    // Count cycles with the door open, pressing the door button on cycle btnCycle
    task automatic measureDoor(input int btnCycle, output int n);
        n = 0;
        while (bus.door_open === 1'b1 && n < WAIT_LIMIT) begin
            n++;
            bus.door_btn = (n == btnCycle);
            @(negedge clk);
        end
        bus.door_btn = 1'b0;
    endtask

    // Count cycles spent closing, pressing the door button on cycle btnCycle
    task automatic measureClose(input int btnCycle, output int n);
        n = 0;
        while (bus.state === ST_CLOSE && n < WAIT_LIMIT) begin
            n++;
            bus.door_btn = (n == btnCycle);
            @(negedge clk);
        end
        bus.door_btn = 1'b0;
    endtask

    // Directed scenario sequence
    initial begin
        int         n;
        int         opensBefore;
        logic [2:0] st;

        rstn         = 1'b0;
        bus.req_btn  = 4'b0000;
        bus.door_btn = 1'b0;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_state", {29'b0, bus.state}, {29'b0, ST_IDLE});
        check("rst_motor_up", {31'b0, bus.motor_up}, 32'd0);
        check("rst_motor_down", {31'b0, bus.motor_down}, 32'd0);
        check("rst_door", {31'b0, bus.door_open}, 32'd0);
        check("rst_req_led", {28'b0, bus.req_led}, 32'd0);
        check("rst_cur_floor", {30'b0, bus.cur_floor}, 32'd0);
        check("rst_dir_up", {31'b0, bus.dir_up}, 32'd1);

        // Car parked at floor 1; a call for floor 0 right after reset must wait for the floor
        rstn = 1'b1;
        applyStimulus(4'b0001);
        check("boot_wait_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});
        check("boot_req_latched", {28'b0, bus.req_led}, 32'd1);
        waitLeave(ST_IDLE, st);
        check("boot_first_move", {29'b0, st}, {29'b0, ST_DOWN});
        check("boot_cur_floor", {30'b0, bus.cur_floor}, 32'd1);
        waitState(ST_OPEN, "boot_arrive");
        check("boot_at_floor0", {30'b0, bus.cur_floor}, 32'd0);
        check("boot_dir_down", {31'b0, bus.dir_up}, 32'd0);
        measureDoor(0, n);
        measureClose(0, n);
        check("boot_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});

        // Floor 0 to floor 3 without stopping on the way
        opensBefore = doorOpens;
        applyStimulus(4'b1000);
        waitState(ST_UP, "up_start");
        waitState(ST_OPEN, "up_arrive");
        check("up_floor3", {30'b0, bus.cur_floor}, 32'd3);
        check("up_req_cleared", {28'b0, bus.req_led}, 32'd0);
        check("up_motor_off", {31'b0, bus.motor_up}, 32'd0);
        check("up_dir", {31'b0, bus.dir_up}, 32'd1);
        measureDoor(0, n);
        check("up_door_len", n, DOOR_TICKS);
        check("up_single_stop", doorOpens - opensBefore, 32'd1);
        measureClose(0, n);
        check("up_close_len", n, CLOSE_TICKS);
        check("up_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});

        // Door button on open cycle 6 extends the open phase by a full period
        applyStimulus(4'b1000);
        waitState(ST_OPEN, "btn_open");
        check("btn_req_not_latched", {28'b0, bus.req_led}, 32'd0);
        measureDoor(6, n);
        check("btn_door_len", n, 6 + DOOR_TICKS);
        measureClose(0, n);
        check("btn_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});

        // Door button on close cycle 2
        applyStimulus(4'b1000);
        waitState(ST_OPEN, "reopen_open");
        measureDoor(0, n);
        measureClose(2, n);
`ifdef ELEV_DOOR_REOPEN_EN
        check("reopen_close_len", n, 2);
        check("reopen_state", {29'b0, bus.state}, {29'b0, ST_OPEN});
        measureDoor(0, n);
        check("reopen_door_len", n, DOOR_TICKS);
        measureClose(0, n);
        check("reopen_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});
`else
        check("noreopen_close_len", n, CLOSE_TICKS);
        check("noreopen_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});
        check("noreopen_door", {31'b0, bus.door_open}, 32'd0);
`endif

        // Back down to floor 0, then up with calls for 0 and 3 made at floor 1
        applyStimulus(4'b0001);
        waitState(ST_OPEN, "rev_down_arrive");
        measureDoor(0, n);
        measureClose(0, n);
        check("rev_idle_floor0", {30'b0, bus.cur_floor}, 32'd0);
        applyStimulus(4'b1000);
        waitState(ST_UP, "rev_up_start");
        waitFloor(2'd1, "rev_at_floor1");
        applyStimulus(4'b1001);
        check("rev_both_latched", {28'b0, bus.req_led}, 32'd9);
        waitState(ST_OPEN, "rev_serve3");
        check("rev_first_floor3", {30'b0, bus.cur_floor}, 32'd3);
        check("rev_pending0", {28'b0, bus.req_led}, 32'd1);
        measureDoor(0, n);
        measureClose(0, n);
        check("rev_reverse", {29'b0, bus.state}, {29'b0, ST_DOWN});
        check("rev_dir_down", {31'b0, bus.dir_up}, 32'd0);
        waitState(ST_OPEN, "rev_serve0");
        check("rev_floor0", {30'b0, bus.cur_floor}, 32'd0);
        check("rev_req_empty", {28'b0, bus.req_led}, 32'd0);
        measureDoor(0, n);
        measureClose(0, n);
        check("rev_end_dir", {31'b0, bus.dir_up}, 32'd0);

        // Ambiguous sensor pattern is not a floor
        snsForced   = 4'b0110;
        snsOverride = 1'b1;
        repeat (5) @(negedge clk);
        check("amb_idle_floor", {30'b0, bus.cur_floor}, 32'd0);
        applyStimulus(4'b0100);
        repeat (10) @(negedge clk);
        check("amb_still_moving", {29'b0, bus.state}, {29'b0, ST_UP});
        check("amb_floor_held", {30'b0, bus.cur_floor}, 32'd0);
        snsOverride = 1'b0;
        waitState(ST_OPEN, "amb_arrive");
        check("amb_floor2", {30'b0, bus.cur_floor}, 32'd2);
        measureDoor(0, n);
        measureClose(0, n);

        // Asynchronous reset in the middle of an upward move
        applyStimulus(4'b1000);
        waitState(ST_UP, "mid_move");
        check("mid_motor_on", {31'b0, bus.motor_up}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_motor", {31'b0, bus.motor_up}, 32'd0);
        check("mid_rst_state", {29'b0, bus.state}, {29'b0, ST_IDLE});
        check("mid_rst_req", {28'b0, bus.req_led}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", {29'b0, bus.state}, {29'b0, ST_IDLE});
        check("post_rst_req", {28'b0, bus.req_led}, 32'd0);
        check("post_rst_floor", {30'b0, bus.cur_floor}, 32'd2);

        check("motors_exclusive", {31'b0, bothSeen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
